// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_reader
//  Purpose  : Reads a burst of consecutive words from a synchronous-read RAM
//             port and presents them in order on a valid/ready stream.
//             Addresses wrap from NUM_WORDS-1 back to 0.
//  Revision : 1.0  initial release
// ============================================================================
module ram_burst_reader #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8,
    parameter int NUM_WORDS = 2**ADDR_BITS
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic [ADDR_BITS-1:0] in_base_addr,
    input  logic [ADDR_BITS:0]   in_len,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_ram_read_ena,
    output logic                 out_ram_write_ena,
    output logic [ADDR_BITS-1:0] out_ram_addr,
    input  logic [WORD_BITS-1:0] in_ram_data,
    output logic                 out_valid,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_last,
    input  logic                 in_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] c_last_addr = ADDR_BITS'(NUM_WORDS - 1);
    localparam logic [ADDR_BITS-1:0] c_addr_one  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   c_len_one   = (ADDR_BITS+1)'(1);

    state_t                r_state;
    state_t                w_state_next;

    // Issue side
    logic [ADDR_BITS-1:0]  r_cur_addr;
    logic [ADDR_BITS:0]    r_issue_left;
    logic                  r_ram_read_ena;
    logic [ADDR_BITS-1:0]  r_ram_addr;
    logic                  r_re_last;
    logic                  r_pend;
    logic                  r_pend_last;

    // Two-entry holding buffer, entry 0 is the oldest word
    logic [WORD_BITS-1:0]  r_fifo_data [0:1];
    logic                  r_fifo_last [0:1];
    logic [1:0]            r_fifo_cnt;

    // Stream output register and status flags
    logic                  r_valid;
    logic [WORD_BITS-1:0]  r_data;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_xfer;
    logic                  w_out_free;
    logic                  w_fifo_pop;
    logic                  w_fifo_push;
    logic                  w_push_idx;
    logic [2:0]            w_hold;
    logic                  w_issue;
    logic [ADDR_BITS-1:0]  w_next_addr;

    // Datapath control: transfer, buffer moves and read-issue throttle.
    // w_hold counts every word that will still need storage after this edge
    // (buffer, read on the RAM bus, read just issued, output if not taken).
    // Storage is the output register plus two buffer entries, so a new read
    // may go out only while that count is at most 2.
    always_comb begin
        w_xfer      = r_valid & in_ready;
        w_out_free  = ~r_valid | w_xfer;
        w_fifo_pop  = w_out_free & (r_fifo_cnt != 2'd0);
        w_fifo_push = r_pend & ~(w_out_free & (r_fifo_cnt == 2'd0));
        w_push_idx  = ((r_fifo_cnt - {1'b0, w_fifo_pop}) == 2'd1);
        w_hold      = {1'b0, r_fifo_cnt} + {2'b00, r_ram_read_ena}
                    + {2'b00, r_pend} + {2'b00, r_valid & ~in_ready};
        w_issue     = (r_state == S_RUN) && (r_issue_left != '0) && (w_hold <= 3'd2);
        w_next_addr = (r_cur_addr == c_last_addr) ? '0 : (r_cur_addr + c_addr_one);
    end

    // Next-state logic: start only honoured in IDLE, DONE lasts one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_start) begin
                    w_state_next = (in_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer && r_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered status outputs derived from the upcoming state
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
        end
    end

    // Read issue: latch burst on start, then walk addresses under the throttle
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_cur_addr     <= '0;
            r_issue_left   <= '0;
            r_ram_read_ena <= 1'b0;
            r_ram_addr     <= '0;
            r_re_last      <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_last    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && in_start && (in_len != '0)) begin
                r_cur_addr   <= in_base_addr;
                r_issue_left <= in_len;
            end
            if (w_issue) begin
                r_ram_read_ena <= 1'b1;
                r_ram_addr     <= r_cur_addr;
                r_re_last      <= (r_issue_left == c_len_one);
                r_cur_addr     <= w_next_addr;
                r_issue_left   <= r_issue_left - c_len_one;
            end else begin
                r_ram_read_ena <= 1'b0;
            end
            // Read data appears on the RAM bus the cycle after the enable
            r_pend      <= r_ram_read_ena;
            r_pend_last <= r_re_last;
        end
    end

    // Holding buffer: shift out the head, capture bus data behind it
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            if (w_fifo_pop) begin
                r_fifo_data[0] <= r_fifo_data[1];
                r_fifo_last[0] <= r_fifo_last[1];
            end
            if (w_fifo_push) begin
                if (w_push_idx) begin
                    r_fifo_data[1] <= in_ram_data;
                    r_fifo_last[1] <= r_pend_last;
                end else begin
                    r_fifo_data[0] <= in_ram_data;
                    r_fifo_last[0] <= r_pend_last;
                end
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_fifo_push} - {1'b0, w_fifo_pop};
        end
    end

    // Output register: refill from buffer first, else straight from the bus
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (w_out_free) begin
            if (r_fifo_cnt != 2'd0) begin
                r_valid <= 1'b1;
                r_data  <= r_fifo_data[0];
                r_last  <= r_fifo_last[0];
            end else if (r_pend) begin
                r_valid <= 1'b1;
                r_data  <= in_ram_data;
                r_last  <= r_pend_last;
            end else begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign out_busy          = r_busy;
    assign out_done          = r_done;
    assign out_ram_read_ena  = r_ram_read_ena;
    assign out_ram_write_ena = 1'b0;
    assign out_ram_addr      = r_ram_addr;
    assign out_valid         = r_valid;
    assign out_data          = r_data;
    assign out_last          = r_last;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_burst_reader
//  Purpose  : Directed, table-driven bench for ram_burst_reader with a
//             synchronous-read RAM model holding 8'h10+i at address i.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_burst_reader;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_start;
    logic [2:0] in_base_addr;
    logic [3:0] in_len;
    logic       out_busy;
    logic       out_done;
    logic       out_ram_read_ena;
    logic       out_ram_write_ena;
    logic [2:0] out_ram_addr;
    logic [7:0] in_ram_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       in_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:7];

    typedef struct {
        logic [2:0] base;
        logic [3:0] len;
        bit         stall;       // in_ready pattern 1,0,0 repeating
        bit         poke;        // extra start pulse while running
        int         exp_first_read;   // cycle index after start edge, -1 none
        int         exp_first_valid;
        int         exp_done;         // -2 means not checked
    } vec_t;

    vec_t vecs [7];

    ram_burst_reader #(
        .ADDR_BITS(3),
        .WORD_BITS(8),
        .NUM_WORDS(8)
    ) dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_start         (in_start),
        .in_base_addr     (in_base_addr),
        .in_len           (in_len),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_ram_read_ena (out_ram_read_ena),
        .out_ram_write_ena(out_ram_write_ena),
        .out_ram_addr     (out_ram_addr),
        .in_ram_data      (in_ram_data),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .in_ready         (in_ready)
    );

    always #5 in_clk = ~in_clk;

    // Synchronous-read RAM: data one cycle after enable, zero otherwise
    always @(posedge in_clk) begin
        in_ram_data <= out_ram_read_ena ? mem[out_ram_addr] : 8'h00;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int         c;
        int         reads, words, dones, issued, outst, max_out;
        int         first_read, first_valid, done_cyc;
        int         stab_err, busy_err;
        bit         we_seen, ready_now, prev_stall;
        logic [7:0] prev_data, exp_data;
        logic [2:0] exp_addr, word_addr;
        reads = 0; words = 0; dones = 0; issued = 0; max_out = 0;
        first_read = -1; first_valid = -1; done_cyc = -1;
        stab_err = 0; busy_err = 0; we_seen = 0; prev_stall = 0; prev_data = '0;
        exp_addr = v.base;
        @(negedge in_clk);
        in_start = 1'b1; in_base_addr = v.base; in_len = v.len; in_ready = 1'b1;
        @(posedge in_clk);
        c = 0;
        while (1) begin
            @(negedge in_clk);
            in_start = (v.poke && c == 2);
            if (v.poke && c == 2) begin
                in_base_addr = ~v.base;
                in_len       = 4'd1;
            end
            ready_now = v.stall ? (c % 3 == 0) : 1'b1;
            in_ready  = ready_now;
            if (out_ram_write_ena) we_seen = 1;
            if (!out_busy && done_cyc < 0) busy_err++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            if (out_ram_read_ena) begin
                if (first_read < 0) first_read = c;
                check("read_addr", out_ram_addr, exp_addr);
                exp_addr = exp_addr + 3'd1;
                reads++;
                issued++;
            end
            outst = issued - words - int'(out_valid);
            if (outst > max_out) max_out = outst;
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                word_addr = v.base + 3'(words);
                exp_data  = 8'h10 + {5'b0, word_addr};
                check("word_data", out_data, exp_data);
                check("word_last", out_last, (words == int'(v.len) - 1));
                if (ready_now) words++;
            end
            prev_stall = out_valid && !ready_now;
            prev_data  = out_data;
            if (out_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c > done_cyc) break;
            if (c >= 80) break;
            c++;
        end
        in_start = 1'b0;
        in_ready = 1'b1;
        check("done_seen", (done_cyc >= 0), 1);
        check("read_count", reads, v.len);
        check("word_count", words, v.len);
        check("done_pulses", dones, 1);
        check("first_read_cycle", first_read, v.exp_first_read);
        check("first_valid_cycle", first_valid, v.exp_first_valid);
        if (v.exp_done != -2) check("done_cycle", done_cyc, v.exp_done);
        check("outstanding_le2", (max_out <= 2), 1);
        check("write_ena_low", we_seen, 0);
        check("stall_hold", stab_err, 0);
        check("busy_during_burst", busy_err, 0);
        check("busy_after_done", out_busy, 0);
        check("done_after_done", out_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);

        vecs[0] = '{base: 3'd2, len: 4'd4, stall: 0, poke: 0, exp_first_read: 1, exp_first_valid: 3, exp_done: 7};
        vecs[1] = '{base: 3'd6, len: 4'd4, stall: 0, poke: 0, exp_first_read: 1, exp_first_valid: 3, exp_done: 7};
        vecs[2] = '{base: 3'd0, len: 4'd8, stall: 1, poke: 0, exp_first_read: 1, exp_first_valid: 3, exp_done: -2};
        vecs[3] = '{base: 3'd5, len: 4'd0, stall: 0, poke: 0, exp_first_read: -1, exp_first_valid: -1, exp_done: 0};
        vecs[4] = '{base: 3'd3, len: 4'd4, stall: 0, poke: 1, exp_first_read: 1, exp_first_valid: 3, exp_done: 7};
        vecs[5] = '{base: 3'd7, len: 4'd1, stall: 0, poke: 0, exp_first_read: 1, exp_first_valid: 3, exp_done: 4};
        vecs[6] = '{base: 3'd0, len: 4'd8, stall: 0, poke: 0, exp_first_read: 1, exp_first_valid: 3, exp_done: 11};

        in_rst = 1'b0; in_start = 1'b0; in_base_addr = '0; in_len = '0; in_ready = 1'b1;
        repeat (3) @(negedge in_clk);
        check("reset_outputs",
              {out_busy, out_done, out_valid, out_last, out_data, out_ram_read_ena, out_ram_addr}, 0);
        in_rst = 1'b1;
        @(negedge in_clk);

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // Reset in the middle of a long burst, while the second word is shown
        @(negedge in_clk);
        in_start = 1'b1; in_base_addr = 3'd0; in_len = 4'd8; in_ready = 1'b1;
        @(posedge in_clk);
        @(negedge in_clk);
        in_start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge in_clk);
            if (out_valid && out_data == 8'h11) begin
                found = 1;
                break;
            end
        end
        check("second_word_seen", found, 1);
        @(posedge in_clk);
        #1 in_rst = 1'b0;
        #1 check("midburst_reset_outputs",
                 {out_busy, out_done, out_valid, out_last, out_data, out_ram_read_ena, out_ram_addr}, 0);
        #1 in_rst = 1'b1;
        repeat (3) @(negedge in_clk);
        check("post_reset_idle", {out_valid, out_busy, out_ram_read_ena}, 0);
        run_burst('{base: 3'd0, len: 4'd2, stall: 0, poke: 0,
                    exp_first_read: 1, exp_first_valid: 3, exp_done: 5});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
